btb_ctrl: RTL
=============

Name: btb_ctrl

Overview:
- Sequencing controller for the 2-way, 8-set branch target buffer storage array.
- Serves single-cycle fetch-stage lookups and accepts resolved-branch updates from execute through a valid/ready handshake.
- Performs update read-modify-write, victim selection, 2-bit counter training and LRU maintenance, plus a full-array flush walk.
- Sits between fetch/execute and the BTB storage array. Owns the array's read-set and write ports exclusively.

Parameters:
- SETS, 8, number of sets; must be a power of 2.
- IDXW, 3, set index width; must equal log2(SETS).
- TAGW, 27, tag width; must equal 30-IDXW.
- STATW, 32, width of statistics counters (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- lookup_pc  in  32  fetch PC. Index = pc[IDXW+1:2]; tag = pc[31:IDXW+2].
- lookup_ready  out  1  high when prediction outputs are valid this cycle.
- pred_hit  out  1  lookup PC hit a valid way.
- pred_taken  out  1  hit and counter MSB=1.
- pred_target  out  32  hit way target; 0 on miss.
- upd_valid  in  1  resolved-branch update request.
- upd_ready  out  1  update accepted when upd_valid & upd_ready.
- upd_pc  in  32  resolved branch PC.
- upd_taken  in  1  actual outcome.
- upd_target  in  32  actual target.
- flush_req  in  1  one-cycle request to invalidate the entire array.
- flush_busy  out  1  flush pending or in progress.
- flush_done  out  1  one-cycle pulse when flush completes.
- bf_rd_set  out  IDXW  array read set.
- bf_rd_valid0/1  in  1 each  per-way valid.
- bf_rd_tag0/1  in  TAGW each  per-way tag.
- bf_rd_target0/1  in  32 each  per-way target.
- bf_rd_state0/1  in  2 each  per-way counter.
- bf_rd_lru  in  1  LRU bit of the read set; its value is the way to replace next.
- bf_wr_en, bf_wr_set[IDXW], bf_wr_way[1], bf_wr_valid[1], bf_wr_tag[TAGW], bf_wr_target[32], bf_wr_state[2]  out  array write port.
- bf_wr_lru_en[1], bf_wr_lru_val[1]  out  LRU write. Uses bf_wr_set.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset: state=IDLE; all update/flush registers cleared; flush_busy=0, flush_done=0, bf_wr_en=0, bf_wr_lru_en=0. lookup_ready=1 and upd_ready=1 (combinational from IDLE). Reset mid-update or mid-flush abandons the operation with no further writes.
- States: IDLE, UPD_RD, UPD_WR, FLUSH.
- IDLE:
  - bf_rd_set = lookup index. Prediction is combinational, zero latency.
  - Way0 has priority if both ways match.
  - upd_ready = !flush_pend.
  - flush_req (or flush_pend) takes priority over upd_valid in the same cycle: go to FLUSH and clear flush_pend.
  - Otherwise, on update accept, register upd_pc/taken/target and go to UPD_RD.
- UPD_RD:
  - bf_rd_set = update index. lookup_ready=0 and pred_hit=pred_taken=0, pred_target=0.
  - Compute hit way, new state, victim, and write decision. Register all of them. Go to UPD_WR.
- UPD_WR (lookup_ready=0):
  - Hit on way w: write valid=1, tag, state = saturating (taken ? +1 : -1) over 0..3. Target = upd_target if taken, else the old target. LRU ← ~w.
  - Miss and taken: victim = first invalid way (way0 before way1), else bf_rd_lru. Write valid=1, tag, target, state=2'b10. LRU ← ~victim.
  - Miss and not taken: no write (bf_wr_en=0, bf_wr_lru_en=0).
  - Return to IDLE. The write is visible to the lookup in the cycle after UPD_WR.
  - Update latency: accept at T, write at T+2, first-hit lookup at T+3.
- FLUSH:
  - 2*SETS cycles, driven by a counter c (IDXW+1 bits) running 0..2*SETS-1. Each cycle writes set=c[IDXW:1], way=c[0], valid=0, tag=0, target=0, state=2'b01.
  - On way1 writes, also drive bf_wr_lru_en=1 with lru_val=0.
  - lookup_ready=0 and upd_ready=0 throughout. flush_busy=1.
  - After the last write, return to IDLE. flush_done pulses for one cycle in the first IDLE cycle and flush_busy drops in that same cycle.
- flush_req during UPD_RD/UPD_WR: latch flush_pend (flush_busy=1). Flush starts right after UPD_WR. The update completes first.
- flush_req during FLUSH: ignored; no restart.

Optional Feature:
- Macro: BTB_STATS_EN.
- When defined, add outputs stat_lookups, stat_hits, stat_allocs (each STATW bits).
  - stat_lookups increments on every IDLE cycle.
  - stat_hits increments on every IDLE cycle with pred_hit=1.
  - stat_allocs increments on every miss-and-taken write.
  - All three saturate at all-ones, reset to 0, and are cleared in the first FLUSH cycle.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset, then lookup_pc=0x00001004 → lookup_ready=1, pred_hit=0, pred_taken=0, pred_target=0.
2. Update pc=0x00001004, taken=1, target=0x00002000 accepted at T → at T+2: bf_wr_en=1, set=1, way=0, state=2'b10, LRU val=1. Lookup at T+3 → hit=1, taken=1, target=0x00002000.
3. Set-1 aliases 0x00001024 then 0x00001044, both taken, after scenario 2 → first fills way1 (LRU←0). Second evicts way0 (bf_rd_lru=0), LRU←1. Lookup 0x00001004 then misses.
4. Counter training on a hit entry, starting at 2'b10:
   - 2 taken updates → 2'b11 (saturates).
   - 3 not-taken updates → 2'b00. Lookup: hit=1, taken=0.
   - A further not-taken update → state stays 2'b00 and target is unchanged.
5. flush_req in IDLE at T → 16 write cycles T+1..T+16 sweeping set 0..7 / way 0,1. flush_done=1 at T+17 only; upd_ready=0 T..T+16. Every lookup afterwards misses.
6. flush_req one cycle after an update is accepted → the update write happens (UPD_WR), then the flush runs. flush_busy=1 from the request until flush_done. A concurrent upd_valid is held off (upd_ready=0).

Source files
------------

// File: rtl/btb_ctrl.sv
// btb_ctrl - sequencing controller for a 2-way, SETS-set branch target buffer.
//
// Purpose:
//   Serves zero-latency fetch lookups from the storage array, accepts resolved
//   branch updates from execute, performs the update read-modify-write (hit
//   training, victim allocation, LRU maintenance) and walks the whole array on
//   a flush request. This block is the only master of the array read-set and
//   write ports.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   lookup_pc                    fetch PC (index pc[IDXW+1:2], tag pc[31:IDXW+2])
//   lookup_ready                 prediction outputs valid this cycle (IDLE only)
//   pred_hit/taken/target        prediction for lookup_pc
//   upd_valid/ready              update handshake
//   upd_pc/taken/target          resolved branch information
//   flush_req                    one-cycle request to invalidate the array
//   flush_busy, flush_done       flush pending/running, completion pulse
//   bf_rd_*                      array read port (set out, way contents in)
//   bf_wr_*                      array write port, bf_wr_lru_* shares bf_wr_set
//
// Handshake: an update transfers in a cycle where upd_valid & upd_ready are
// both high; upd_ready is only high in IDLE with no flush requested or pending,
// and does not depend on upd_valid.
//
// Optional build macro BTB_STATS_EN adds saturating statistics counters
// stat_lookups, stat_hits and stat_allocs (STATW bits each).

module btb_ctrl #(
    parameter int SETS = 8,
    parameter int IDXW = 3,
    parameter int TAGW = 27
`ifdef BTB_STATS_EN
    ,
    parameter int STATW = 32
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     lookup_pc,
    output logic            lookup_ready,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [31:0]     pred_target,
    input  logic            upd_valid,
    output logic            upd_ready,
    input  logic [31:0]     upd_pc,
    input  logic            upd_taken,
    input  logic [31:0]     upd_target,
    input  logic            flush_req,
    output logic            flush_busy,
    output logic            flush_done,
    output logic [IDXW-1:0] bf_rd_set,
    input  logic            bf_rd_valid0,
    input  logic            bf_rd_valid1,
    input  logic [TAGW-1:0] bf_rd_tag0,
    input  logic [TAGW-1:0] bf_rd_tag1,
    input  logic [31:0]     bf_rd_target0,
    input  logic [31:0]     bf_rd_target1,
    input  logic [1:0]      bf_rd_state0,
    input  logic [1:0]      bf_rd_state1,
    input  logic            bf_rd_lru,
    output logic            bf_wr_en,
    output logic [IDXW-1:0] bf_wr_set,
    output logic            bf_wr_way,
    output logic            bf_wr_valid,
    output logic [TAGW-1:0] bf_wr_tag,
    output logic [31:0]     bf_wr_target,
    output logic [1:0]      bf_wr_state,
    output logic            bf_wr_lru_en,
    output logic            bf_wr_lru_val
`ifdef BTB_STATS_EN
    ,
    output logic [STATW-1:0] stat_lookups,
    output logic [STATW-1:0] stat_hits,
    output logic [STATW-1:0] stat_allocs
`endif
);

    typedef enum logic [1:0] {IDLE, UPD_RD, UPD_WR, FLUSH} state_e;

    localparam logic [IDXW:0] FLUSH_LAST = (IDXW+1)'(2*SETS-1);

    state_e          state_q;
    logic [29:0]     upd_pc_q;        // word address; byte offset is never used
    logic            upd_taken_q;
    logic [31:0]     upd_target_q;
    logic            flush_pend_q;
    logic            flush_done_q;
    logic [IDXW:0]   fcnt_q;          // {set, way} of the current flush write

    // Write decision computed in UPD_RD, applied in UPD_WR.
    logic            wr_do_q, wr_do_d;
    logic            wr_way_q, wr_way_d;
    logic            wr_alloc_q, wr_alloc_d;
    logic [31:0]     wr_target_q, wr_target_d;
    logic [1:0]      wr_state_q, wr_state_d;

    logic            in_idle, in_flush;
    logic [IDXW-1:0] lk_idx, up_idx;
    logic [TAGW-1:0] lk_tag, up_tag, cmp_tag;
    logic            hit0, hit1;
    logic [1:0]      old_state;
    logic            unused_pc_bits;

    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign in_idle  = (state_q == IDLE);
    assign in_flush = (state_q == FLUSH);
    assign lk_idx   = lookup_pc[IDXW+1:2];
    assign lk_tag   = lookup_pc[31:IDXW+2];
    assign up_idx   = upd_pc_q[IDXW-1:0];
    assign up_tag   = upd_pc_q[29:IDXW];

    // One tag comparator pair serves both lookups (IDLE) and updates (UPD_RD).
    assign bf_rd_set = in_idle ? lk_idx : up_idx;
    assign cmp_tag   = in_idle ? lk_tag : up_tag;
    assign hit0      = bf_rd_valid0 && (bf_rd_tag0 == cmp_tag);
    assign hit1      = bf_rd_valid1 && (bf_rd_tag1 == cmp_tag);

    // Prediction: way0 wins when both ways match.
    assign lookup_ready = in_idle;
    assign pred_hit     = in_idle && (hit0 || hit1);
    assign pred_taken   = pred_hit && (hit0 ? bf_rd_state0[1] : bf_rd_state1[1]);
    assign pred_target  = !pred_hit ? 32'd0 : (hit0 ? bf_rd_target0 : bf_rd_target1);

    // A same-cycle flush request wins over an update, so ready drops with it.
    assign upd_ready  = in_idle && !flush_pend_q && !flush_req;
    assign flush_busy = flush_pend_q || in_flush || flush_req;
    assign flush_done = flush_done_q;

    // Update decision from the array contents of the update set.
    assign old_state = hit0 ? bf_rd_state0 : bf_rd_state1;

    always_comb begin
        wr_do_d     = 1'b0;
        wr_alloc_d  = 1'b0;
        wr_way_d    = 1'b0;
        wr_target_d = upd_target_q;
        wr_state_d  = 2'b10;
        if (hit0 || hit1) begin
            wr_do_d  = 1'b1;
            wr_way_d = !hit0;
            if (upd_taken_q) begin
                wr_state_d = (old_state == 2'b11) ? 2'b11 : old_state + 2'd1;
            end else begin
                wr_state_d  = (old_state == 2'b00) ? 2'b00 : old_state - 2'd1;
                wr_target_d = hit0 ? bf_rd_target0 : bf_rd_target1;
            end
        end else if (upd_taken_q) begin
            // Allocate: first invalid way, otherwise the LRU way.
            wr_do_d    = 1'b1;
            wr_alloc_d = 1'b1;
            wr_way_d   = !bf_rd_valid0 ? 1'b0 : (!bf_rd_valid1 ? 1'b1 : bf_rd_lru);
        end
    end

    // Array write port: flush sweep or the registered update write.
    assign bf_wr_en      = in_flush || ((state_q == UPD_WR) && wr_do_q);
    assign bf_wr_set     = in_flush ? fcnt_q[IDXW:1] : up_idx;
    assign bf_wr_way     = in_flush ? fcnt_q[0] : wr_way_q;
    assign bf_wr_valid   = (state_q == UPD_WR);
    assign bf_wr_tag     = in_flush ? '0 : up_tag;
    assign bf_wr_target  = in_flush ? 32'd0 : wr_target_q;
    assign bf_wr_state   = in_flush ? 2'b01 : wr_state_q;
    assign bf_wr_lru_en  = in_flush ? fcnt_q[0] : ((state_q == UPD_WR) && wr_do_q);
    assign bf_wr_lru_val = in_flush ? 1'b0 : !wr_way_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            upd_pc_q     <= '0;
            upd_taken_q  <= 1'b0;
            upd_target_q <= '0;
            flush_pend_q <= 1'b0;
            flush_done_q <= 1'b0;
            fcnt_q       <= '0;
            wr_do_q      <= 1'b0;
            wr_way_q     <= 1'b0;
            wr_alloc_q   <= 1'b0;
            wr_target_q  <= '0;
            wr_state_q   <= '0;
        end else begin
            flush_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (flush_req || flush_pend_q) begin
                        state_q      <= FLUSH;
                        flush_pend_q <= 1'b0;
                        fcnt_q       <= '0;
                    end else if (upd_valid) begin
                        upd_pc_q     <= upd_pc[31:2];
                        upd_taken_q  <= upd_taken;
                        upd_target_q <= upd_target;
                        state_q      <= UPD_RD;
                    end
                end
                UPD_RD: begin
                    wr_do_q     <= wr_do_d;
                    wr_way_q    <= wr_way_d;
                    wr_alloc_q  <= wr_alloc_d;
                    wr_target_q <= wr_target_d;
                    wr_state_q  <= wr_state_d;
                    if (flush_req) flush_pend_q <= 1'b1;
                    state_q <= UPD_WR;
                end
                UPD_WR: begin
                    // The update write happens this cycle; a pending flush follows directly.
                    if (flush_req || flush_pend_q) begin
                        state_q      <= FLUSH;
                        flush_pend_q <= 1'b0;
                        fcnt_q       <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                FLUSH: begin
                    if (fcnt_q == FLUSH_LAST) begin
                        state_q      <= IDLE;
                        flush_done_q <= 1'b1;
                    end else begin
                        fcnt_q <= fcnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef BTB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_lookups <= '0;
            stat_hits    <= '0;
            stat_allocs  <= '0;
        end else if (in_flush && (fcnt_q == '0)) begin
            stat_lookups <= '0;
            stat_hits    <= '0;
            stat_allocs  <= '0;
        end else begin
            if (in_idle && (stat_lookups != '1)) stat_lookups <= stat_lookups + 1'b1;
            if (pred_hit && (stat_hits != '1)) stat_hits <= stat_hits + 1'b1;
            if ((state_q == UPD_WR) && wr_alloc_q && (stat_allocs != '1))
                stat_allocs <= stat_allocs + 1'b1;
        end
    end
`endif

endmodule
